// File: rtl/obm_dma_controller.sv
// Bulk copy of one RAM page into Object Memory through the shared foreground VRAM write port.
// Optional OBM_DMA_VBLANK_GATE_EN: new byte reads start only while vblank is high.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module obm_dma_controller #(
    parameter int          NUM_BYTES = 256,
    parameter logic [11:0] OBM_BASE  = 12'h800
) (
    input  logic                        cpu_clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  src_page,
    input  logic                        vblank,
    output logic                        mem_req,
    output logic [15:0]                 mem_addr,
    input  logic                        mem_ack,
    input  logic [7:0]                  mem_rdata,
    input  logic                        cpu_vram_req,
    output logic                        vram_we,
    output logic [`VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]                  vram_wdata,
    output logic                        busy,
    output logic                        done
);
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int AW = `VRAM_ADDR_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_VB, READ, WRITE, FINISH} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [7:0]    page;
    logic [7:0]    data;
    logic [7:0]    idx8;
    logic          commit;

    assign idx8 = 8'(idx);

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            page  <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:    if (start) begin
                             page <= src_page;
                             idx  <= '0;
                         end
                READ:    if (mem_ack) data <= mem_rdata;
                WRITE:   if (commit && idx != LAST_IDX) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_addr     = '0;
        vram_we      = 1'b0;
        vram_address = '0;
        vram_wdata   = '0;
        busy         = 1'b1;
        done         = 1'b0;
        commit       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = WAIT_VB;
            end
            WAIT_VB: begin
                if (vblank) state_nxt = READ;
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = {page, idx8};
                if (mem_ack) state_nxt = WRITE;
            end
            WRITE: begin
                // CPU owns the port whenever it asks; address and data simply hold.
                commit       = !cpu_vram_req;
                vram_we      = commit;
                vram_address = AW'(OBM_BASE) + AW'(idx);
                vram_wdata   = data;
                if (commit) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = FINISH;
                    end else begin
`ifdef OBM_DMA_VBLANK_GATE_EN
                        state_nxt = vblank ? READ : WAIT_VB;
`else
                        state_nxt = READ;
`endif
                    end
                end
            end
            FINISH: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
